// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned engine: shift-add multiply or restoring divide on {hi, lo}.
// Purely combinational; the caller registers the result each CALC cycle.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_hi_i,
    input  logic [WIDTH-1:0] acc_lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] nxt_hi_o,
    output logic [WIDTH-1:0] nxt_lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    always_comb begin
        sum    = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        shl    = {acc_hi_i, acc_lo_i[WIDTH-1]};
        borrow = shl < {1'b0, opnd_i};
        // Without a borrow the true difference is below the divisor, so it fits in WIDTH bits.
        diff   = shl[WIDTH-1:0] - opnd_i;
        nxt_hi_o = sum[WIDTH:1];
        nxt_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
        if (is_div_i) begin
            nxt_hi_o = borrow ? shl[WIDTH-1:0] : diff;
            nxt_lo_o = {acc_lo_i[WIDTH-2:0], ~borrow};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle mult/multu/div/divu sequencer owning HI/LO; 33 busy cycles per operation.
// Operands become magnitudes on entry, the step engine runs unsigned, FIX restores signs.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(STEPS);

    md_state_t        state_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q, neg_q, rem_neg_q, dz_q, done_q;
    logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
    logic [WIDTH-1:0] acc_hi_d, acc_lo_d, hi_d, lo_d;

    muldiv_op_t       op_e;
    logic             is_div_in, signed_in;
    logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign op_e      = muldiv_op_t'(op);
    assign is_div_in = (op_e == MD_DIV) || (op_e == MD_DIVU);
    assign signed_in = (op_e == MD_MULT) || (op_e == MD_DIV);
    // Unsigned WIDTH-bit magnitude is exact even for the most negative value.
    assign a_mag = (signed_in && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_in && b[WIDTH-1]) ? (~b + 1'b1) : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_hi_i (acc_hi_q),
        .acc_lo_i (acc_lo_q),
        .opnd_i   (opnd_q),
        .nxt_hi_o (acc_hi_d),
        .nxt_lo_o (acc_lo_d)
    );

    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        quo_fix  = dz_q ? {WIDTH{1'b1}} : (neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q);
        rem_fix  = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        hi_d     = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d     = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        is_div_q  <= is_div_in;
                        neg_q     <= signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_q <= signed_in && a[WIDTH-1];
                        dz_q      <= is_div_in && (b == '0);
                        opnd_q    <= is_div_in ? b_mag : a_mag;
                        acc_lo_q  <= is_div_in ? a_mag : b_mag;
                        acc_hi_q  <= '0;
                        cnt_q     <= '0;
                        state_q   <= MD_CALC;
                    end else begin
                        if (mthi_en) hi_q <= wdata;
                        if (mtlo_en) lo_q <= wdata;
                    end
                end
                MD_CALC: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(STEPS - 1)) state_q <= MD_FIX;
                end
                MD_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != MD_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, done pulse, mthi/mtlo and reset cases.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, mthi_en, mtlo_en;
    logic [1:0]  op;
    logic [31:0] a, b, wdata, hi, lo;
    logic        busy, done;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi_en (mthi_en),
        .mtlo_en (mtlo_en),
        .wdata   (wdata),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and follow it to completion; with disturb set, also
    // pile mthi/mtlo onto the start cycle and re-issue start mid-operation.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input bit disturb,
                          input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        int cycles = 0;
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        if (disturb) begin
            mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'hAAAA_5555;
        end
        @(posedge clk);
        #1;
        start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) pulses++;
            if (!busy) break;
            cycles++;
            if (disturb && cycles == 1) begin
                check({tag, " hi held at start"}, {32'h0, hi}, {32'h0, hold_hi});
                check({tag, " lo held at start"}, {32'h0, lo}, {32'h0, hold_lo});
            end
            if (disturb && cycles == 5) begin
                start = 1'b1; op = 2'd1; a = 32'h1234_5678; b = 32'h9;
                mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            if (disturb && cycles == 6) begin
                start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
                check({tag, " hi held while busy"}, {32'h0, hi}, {32'h0, hold_hi});
                check({tag, " lo held while busy"}, {32'h0, lo}, {32'h0, hold_lo});
            end
        end
        check({tag, " busy cycles"}, 64'(cycles), 64'd33);
        check({tag, " done at end"}, {63'h0, done}, 64'h1);
        check({tag, " hi"}, {32'h0, hi}, {32'h0, exp_hi});
        check({tag, " lo"}, {32'h0, lo}, {32'h0, exp_lo});
        @(negedge clk);
        check({tag, " done pulse count"}, 64'(pulses + (done ? 1 : 0)), 64'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        mthi_en = 1'b0; mtlo_en = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset hi", {32'h0, hi}, 64'h0);
        check("reset lo", {32'h0, lo}, 64'h0);
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset done", {63'h0, done}, 64'h0);

        run_op("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, '0, '0);
        run_op("mult -7*3", 2'd0, 32'hFFFF_FFF9, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, '0, '0);
        run_op("mult min*min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, '0, '0);
        run_op("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, '0, '0);
        run_op("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, '0, '0);
        run_op("div overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, '0, '0);
        run_op("divu 5/0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, '0, '0);
        run_op("div -5/0", 2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, '0, '0);

        @(negedge clk);
        mthi_en = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk);
        #1 mthi_en = 1'b0;
        @(negedge clk);
        check("mthi hi", {32'h0, hi}, 64'h1234);
        check("mthi lo untouched", {32'h0, lo}, 64'hFFFF_FFFF);
        mthi_en = 1'b1; mtlo_en = 1'b1; wdata = 32'h0000_5678;
        @(posedge clk);
        #1 begin mthi_en = 1'b0; mtlo_en = 1'b0; end
        @(negedge clk);
        check("mthi+mtlo hi", {32'h0, hi}, 64'h5678);
        check("mthi+mtlo lo", {32'h0, lo}, 64'h5678);

        run_op("divu disturbed", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 32'h5678, 32'h5678);

        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(negedge clk);
        check("busy before reset", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid-op reset busy", {63'h0, busy}, 64'h0);
        check("mid-op reset hi", {32'h0, hi}, 64'h0);
        check("mid-op reset lo", {32'h0, lo}, 64'h0);
        check("mid-op reset done", {63'h0, done}, 64'h0);

        run_op("after reset divu", 2'd3, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, '0, '0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
